// File: rtl/pc_fetch_stage_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t      : fetch sequencer states (BOOT, RUN, HALT)
//   INSTR_W            : instruction width in bits
//   NOP_INSTR          : value left in IF/ID after a squash
//   HALT_INSTR_DEFAULT : default encoding that stops fetch
package fetch_pkg;

   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR          = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_stage_if.sv
// pc_fetch_stage_if: signal bundle between the fetch stage and its surroundings
// (next-PC select, instruction memory, decode stage, pipeline control).
//   master : fetch-stage view (drives imem_addr, pc, pc_plus4, IF/ID, halted)
//   slave  : environment view (drives next_pc, stall, flush, imem_rdata)
// Optional macro PC_FETCH_PERF_COUNT_EN adds fetch_count / stall_count.
interface pc_fetch_stage_if #(
   parameter int N = 32
);
   import fetch_pkg::*;

   logic [N-1:0]       next_pc;
   logic               stall;
   logic               flush;
   logic [INSTR_W-1:0] imem_rdata;
   logic [N-1:0]       imem_addr;
   logic [N-1:0]       pc;
   logic [N-1:0]       pc_plus4;
   logic [INSTR_W-1:0] id_instr;
   logic [N-1:0]       id_pc;
   logic [N-1:0]       id_pc_plus4;
   logic               id_valid;
   logic               halted;
`ifdef PC_FETCH_PERF_COUNT_EN
   logic [31:0]        fetch_count;
   logic [31:0]        stall_count;
`endif

   modport master (
      input  next_pc, stall, flush, imem_rdata,
      output imem_addr, pc, pc_plus4, id_instr, id_pc, id_pc_plus4, id_valid, halted
`ifdef PC_FETCH_PERF_COUNT_EN
      , output fetch_count, stall_count
`endif
   );

   modport slave (
      output next_pc, stall, flush, imem_rdata,
      input  imem_addr, pc, pc_plus4, id_instr, id_pc, id_pc_plus4, id_valid, halted
`ifdef PC_FETCH_PERF_COUNT_EN
      , input fetch_count, stall_count
`endif
   );

endinterface

// File: rtl/pc_fetch_stage_if_id_reg.sv
// if_id_reg: W-bit pipeline register.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   en         : load d when 1, hold when 0
//   clr        : synchronous clear to 0, takes priority over en
//   d, q       : data in / registered data out
module if_id_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples its inputs from before the edge, regardless of process order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= '0;
      else if (clr) q <= '0;
      else if (en)  q <= d;
   end

endmodule

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: instruction-fetch stage. Holds the PC, drives the instruction
// memory address, exports PC+4 to the next-PC select and captures the fetched
// instruction into IF/ID under stall / flush / halt control.
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (master)       : next_pc, stall, flush, imem_rdata in;
//                        imem_addr, pc, pc_plus4, id_instr, id_pc,
//                        id_pc_plus4, id_valid, halted out
// Optional macro PC_FETCH_PERF_COUNT_EN adds saturating fetch_count and
// stall_count outputs on the bus.
module pc_fetch_stage
   import fetch_pkg::*;
#(
   parameter int                 N          = 32,
   parameter logic [N-1:0]       RESET_PC   = '0,
   parameter logic [INSTR_W-1:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   pc_fetch_stage_if.master bus
);

   localparam int BUNDLE_W = INSTR_W + 2 * N + 1;

   fetch_state_t          state_q, state_d;
   logic [N-1:0]          pc_q;
   logic [N-1:0]          pc_inc;
   logic [N-1:0]          pc_aligned;
   logic                  pc_load;
   logic                  reg_en;
   logic                  reg_clr;
   logic                  halted_q;
   logic [BUNDLE_W-1:0]   bundle_d, bundle_q;
   logic [INSTR_W-1:0]    id_instr_q;
   logic [N-1:0]          id_pc_q, id_pc_plus4_q;
   logic                  id_valid_q;

   assign pc_inc     = pc_q + {{(N-3){1'b0}}, 3'b100};        // wraps modulo 2^N
   assign pc_aligned = bus.next_pc & ~{{(N-2){1'b0}}, 2'b11}; // word-aligned target

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= (state_q == HALT);   // rises on the first edge spent in HALT
         if (pc_load) pc_q <= pc_aligned;
      end
   end

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      pc_load = 1'b0;
      reg_en  = 1'b0;
      reg_clr = 1'b0;
      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (bus.flush) begin
               pc_load = 1'b1;
               reg_clr = 1'b1;
            end else if (!bus.stall) begin
               reg_en = 1'b1;
               // The halt instruction is captured, but the PC stops on it.
               if (bus.imem_rdata == HALT_INSTR) state_d = HALT;
               else                              pc_load = 1'b1;
            end
         end
         HALT: reg_en = 1'b1;   // reloads the held bundle with valid dropped
         default: state_d = BOOT;
      endcase
   end

   // In HALT the register reloads its own contents with valid cleared;
   // otherwise it captures the fresh fetch.
   assign bundle_d = (state_q == HALT)
                   ? {id_instr_q, id_pc_q, id_pc_plus4_q, 1'b0}
                   : {bus.imem_rdata, pc_q, pc_inc, 1'b1};

   if_id_reg #(.W(BUNDLE_W)) u_if_id (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (reg_en),
      .clr   (reg_clr),
      .d     (bundle_d),
      .q     (bundle_q)
   );

   assign {id_instr_q, id_pc_q, id_pc_plus4_q, id_valid_q} = bundle_q;

   assign bus.pc          = pc_q;
   assign bus.imem_addr   = pc_q;
   assign bus.pc_plus4    = pc_inc;
   assign bus.id_instr    = id_instr_q;
   assign bus.id_pc       = id_pc_q;
   assign bus.id_pc_plus4 = id_pc_plus4_q;
   assign bus.id_valid    = id_valid_q;
   assign bus.halted      = halted_q;

`ifdef PC_FETCH_PERF_COUNT_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;
   logic        fetch_evt, stall_evt;

   assign fetch_evt = (state_q == RUN) && !bus.flush && !bus.stall;
   assign stall_evt = (state_q == RUN) && !bus.flush &&  bus.stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (fetch_evt && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign bus.fetch_count = fetch_cnt_q;
   assign bus.stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage of the CPU datapath.
- Consumes the 2:1 next-PC select output and holds the program counter.
- Drives the instruction-memory address and exports PC+4 back to the next-PC select's D0 input.
- Captures the fetched instruction into the IF/ID pipeline register, with stall, flush and halt control.

Parameters:
- N, 32, address/PC width in bits (>= 3)
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
- clk  in  1  rising-edge system clock
- rst_n  in  1  asynchronous active-low reset
- next_pc  in  N  selected next PC from the upstream 2:1 select
- stall  in  1  hold PC and IF/ID contents
- flush  in  1  squash IF/ID contents (taken branch/jump)
- imem_rdata  in  32  instruction at imem_addr, combinational read
- imem_addr  out  N  equals pc
- pc  out  N  current program counter
- pc_plus4  out  N  pc + 4, modulo 2^N; feeds the next-PC select's D0
- id_instr  out  32  IF/ID instruction
- id_pc  out  N  IF/ID PC
- id_pc_plus4  out  N  IF/ID PC+4
- id_valid  out  1  IF/ID holds a live instruction
- halted  out  1  fetch stopped in HALT state

Clock/reset (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, any time, including mid-operation):
  - pc=RESET_PC, id_instr=32'h0, id_pc=0, id_pc_plus4=0, id_valid=0, halted=0, state=BOOT.
  - Outputs change immediately, without waiting for a clock edge.
- pc_plus4 and imem_addr: combinational from pc.
- pc_plus4 wraps: pc = 2^N-4 gives pc_plus4 = 0.
- PC load: pc <= {next_pc[N-1:2], 2'b00}; low two bits are always forced to zero.
- FSM states: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after rst_n deasserts.
  - pc holds RESET_PC, id_valid stays 0.
  - stall/flush ignored.
  - Next state: RUN.
- RUN, per rising edge, priority flush > stall > normal:
  - flush=1 (stall ignored): pc <= next_pc; id_instr <= 0; id_pc <= 0; id_pc_plus4 <= 0; id_valid <= 0.
  - stall=1, flush=0: pc and all id_* hold their values.
  - normal: pc <= next_pc; id_instr <= imem_rdata; id_pc <= pc; id_pc_plus4 <= pc_plus4; id_valid <= 1.
  - In the normal case with imem_rdata == HALT_INSTR:
    - The halt instruction is captured into IF/ID with id_valid=1.
    - pc holds (does not load next_pc).
    - State becomes HALT.
  - HALT_INSTR present during stall or flush does not halt.
- HALT:
  - halted=1 (registered; asserted the cycle after entry).
  - pc holds.
  - id_valid <= 0 on the first HALT edge; id_instr/id_pc/id_pc_plus4 hold.
  - stall/flush/next_pc ignored.
  - Only reset exits.
- Latency:
  - next_pc → pc: 1 cycle.
  - imem_rdata → id_instr: 1 cycle.

Optional Feature:
- Macro: PC_FETCH_PERF_COUNT_EN.
- Defined:
  - Adds outputs fetch_count[31:0] and stall_count[31:0]; both reset to 0.
  - fetch_count increments on each normal RUN capture (id_valid <= 1).
  - stall_count increments on each RUN cycle with stall=1 and flush=0.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {BOOT, RUN, HALT}
  - localparam NOP_INSTR = 32'h0000_0000
  - localparam INSTR_W = 32
  - default HALT_INSTR
- Sub-module if_id_reg:
  - Parameterised-width register with async active-low reset, hold-enable and synchronous clear.
  - Instantiated for the instr/pc/pc_plus4/valid bundle.
- pc_fetch_stage holds the FSM and the PC register.

Test Plan:
- Reset and boot:
  - Stimulus: rst_n=0 for 2 cycles, then release; imem_rdata=32'h2001_0005, next_pc=pc_plus4.
  - Response: pc=0 during BOOT; id_valid=0 for the first edge; then pc=4, 8, C; id_instr=32'h2001_0005, id_pc=0, id_pc_plus4=4.
- Stall:
  - Stimulus: at pc=8, stall=1 for 3 cycles.
  - Response: pc stays 8 and id_* unchanged for 3 cycles; release gives pc=C.
- Flush with stall:
  - Stimulus: at pc=C, next_pc=32'h0000_0040, flush=1, stall=1.
  - Response: next pc=40, id_valid=0, id_instr=0; the following cycle captures the instruction at 40.
- Alignment/wrap:
  - Stimulus 1: next_pc=32'h0000_0043.
  - Response 1: pc=40.
  - Stimulus 2: force pc to FFFF_FFFC via next_pc.
  - Response 2: pc_plus4=0.
- Halt:
  - Stimulus: imem_rdata=32'hFFFF_FFFF at pc=10.
  - Response: id_instr=FFFF_FFFF, id_valid=1, pc stays 10; next cycle halted=1, id_valid=0; flush and next_pc ignored thereafter.
- Async reset mid-run:
  - Stimulus: rst_n low between clock edges while at pc=40.
  - Response: pc=0, id_valid=0, halted=0 immediately.
  - With PC_FETCH_PERF_COUNT_EN: fetch_count=0 and stall_count=0 immediately.
